can_tx: RTL
===========

CAN_TX -- requirements
Module: can_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, clock cycles per bit time; legal range 2 to 65535.
REQ-002 SHALL have port i_Clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_Tx_DV  input  1  one-cycle request strobe; i_Tx_Frame is valid in the same cycle.
REQ-005 SHALL have port i_Tx_Frame  input  79  frame image; bit 0 is sent first, bit 78 last; same layout as can_rx o_Rx_Byte.
REQ-006 SHALL have port o_Tx_Ready  output  1  high when the holding register is empty.
REQ-007 SHALL have port o_Tx_Active  output  1  high from the first SOF cycle through the last stop/IFS cycle.
REQ-008 SHALL have port o_Tx_Serial  output  1  bus line; 1 is recessive, 0 is dominant; registered output.
REQ-009 SHALL have port o_Tx_Done  output  1  one-cycle pulse when a frame completes.

Function
REQ-010 SHALL implement states IDLE, SOF, BITS, STOP, IFS, CLEANUP.
REQ-011 SHALL drive o_Tx_Serial to 1 in IDLE, STOP, IFS and CLEANUP.
REQ-012 SHALL, in IDLE with the holding register full, load the shift register from it, clear it, and enter SOF.
REQ-013 SHALL accept i_Tx_DV only when o_Tx_Ready=1, capturing i_Tx_Frame into the holding register; a strobe while o_Tx_Ready=0 SHALL be ignored.
REQ-014 SHALL start SOF on the edge after acceptance when IDLE, so o_Tx_Serial goes 0 exactly one cycle after the i_Tx_DV cycle.
REQ-015 SHALL drive bit 0 as 0 in SOF regardless of i_Tx_Frame[0].
REQ-016 SHALL drive frame bits 1..78 in BITS, in order, each for exactly CLKS_PER_BIT cycles, using a 7-bit index that stops at 78 (no wrap).
REQ-017 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a clock counter that resets to 0 at every bit boundary.
REQ-018 SHALL drive STOP for one bit time (recessive).
REQ-019 SHALL, after STOP, go to IFS when IFS is compiled in, otherwise to CLEANUP.
REQ-020 SHALL pulse o_Tx_Done for one cycle and deassert o_Tx_Active in CLEANUP, then go to IDLE.
REQ-021 SHALL allow a frame queued during transmission to start SOF on the cycle after CLEANUP; no cycle is lost besides IDLE.
REQ-022 SHALL make o_Tx_Ready low from the cycle after acceptance until the holding register is transferred, including when i_Tx_DV arrives in the same cycle as CLEANUP.
REQ-023 SHALL force any illegal state encoding to IDLE with o_Tx_Serial=1.

Reset
REQ-024 SHALL, with i_Reset high on an edge, set the state to IDLE and clear the holding register, counters, index and shift register.
REQ-025 SHALL, after reset, drive o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0 and o_Tx_Done=0.
REQ-026 SHALL, when reset arrives mid-frame, abort immediately with no o_Tx_Done pulse and discard any queued frame.
REQ-027 SHALL give i_Reset priority over i_Tx_DV in the same cycle.

Configuration
REQ-028 SHALL, with macro CAN_TX_IFS_EN defined, insert IFS: 3 recessive bit times after STOP, o_Tx_Active held high.
REQ-029 SHALL, with CAN_TX_IFS_EN undefined, omit the IFS state logic entirely; STOP goes directly to CLEANUP.

Structure
REQ-030 SHALL place the state encodings (4-bit), CAN_FRAME_BITS=79 and CAN_IFS_BITS=3 in shared package can_pkg, also used by can_rx.
REQ-031 SHALL implement the bit-time counter as sub-module can_bit_timer, parameter CLKS_PER_BIT, inputs i_Clock, i_Reset and i_Restart, output o_Bit_Tick, which pulses on the last cycle of each bit time.

Verification (CLKS_PER_BIT=10, i_Tx_DV at cycle N)
REQ-032 SHALL cover: single frame 0x2AAA... alternating pattern -> o_Tx_Serial 0 at N+1; bit k during N+1+10k..N+10+10k; o_Tx_Done at N+801 (N+831 with CAN_TX_IFS_EN).
REQ-033 SHALL cover: i_Tx_Frame[0]=1 -> the SOF bit is still driven 0 for cycles N+1..N+10.
REQ-034 SHALL cover: second i_Tx_DV at N+100 -> accepted, o_Tx_Ready=0; the second SOF starts the cycle after the first CLEANUP; a third strobe at N+200 is ignored.
REQ-035 SHALL cover: i_Reset at N+400 -> o_Tx_Serial=1 the next cycle, no o_Tx_Done, o_Tx_Ready=1, queued frame lost.
REQ-036 SHALL cover: loopback o_Tx_Serial into can_rx i_Rx_Serial with a random frame (bit 0=0) -> can_rx o_Rx_Byte equals i_Tx_Frame when o_Rx_DV pulses.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame constants and transmitter/receiver state encodings.
package can_pkg;

   localparam int CAN_FRAME_BITS = 79;
   localparam int CAN_IFS_BITS   = 3;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_SOF     = 4'd1,
      ST_BITS    = 4'd2,
      ST_STOP    = 4'd3,
      ST_IFS     = 4'd4,
      ST_CLEANUP = 4'd5
   } can_state_e;

endpackage

// File: rtl/can_bit_timer.sv
// Bit-time counter: o_Bit_Tick is high on the last clock of every bit time.
module can_bit_timer #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic i_Restart,
   output logic o_Bit_Tick
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // next count: restart or bit boundary returns to zero
   always_comb begin
      cnt_d = cnt_q;
      if (i_Restart || (cnt_q == LAST_CNT)) begin
         cnt_d = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // counter register
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_Bit_Tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/can_tx.sv
// CAN frame serializer with a one-deep holding register.
// Define CAN_TX_IFS_EN to append a 3-bit recessive interframe space after STOP.
module can_tx
   import can_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Tx_DV,
   input  logic [78:0] i_Tx_Frame,
   output logic        o_Tx_Ready,
   output logic        o_Tx_Active,
   output logic        o_Tx_Serial,
   output logic        o_Tx_Done
);

   localparam logic [6:0] LAST_IDX = 7'(CAN_FRAME_BITS - 1);

   can_state_e  state_q, state_d;
   logic [78:0] shift_q, shift_d;
   logic [78:0] hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [6:0]  idx_q, idx_d;
   logic        serial_q, serial_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic        accept;
   logic        start;
   logic        restart;
   logic        bit_tick;
`ifdef CAN_TX_IFS_EN
   localparam logic [1:0] LAST_IFS = 2'(CAN_IFS_BITS - 1);
   logic [1:0]  ifs_cnt_q, ifs_cnt_d;
`endif

   can_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .i_Restart  (restart),
      .o_Bit_Tick (bit_tick)
   );

   // next-state, shift/hold management and output decode
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      serial_d = serial_q;
      active_d = active_q;
      done_d   = 1'b0;
      restart  = 1'b0;
      start    = 1'b0;
`ifdef CAN_TX_IFS_EN
      ifs_cnt_d = ifs_cnt_q;
`endif
      accept = i_Tx_DV & ~hold_full_q;
      hold_d = accept ? i_Tx_Frame : hold_q;

      case (state_q)
         ST_IDLE: begin
            restart  = 1'b1;
            serial_d = 1'b1;
            // an idle strobe bypasses the holding register so SOF follows immediately
            if (hold_full_q || i_Tx_DV) begin
               state_d  = ST_SOF;
               shift_d  = hold_full_q ? hold_q : i_Tx_Frame;
               start    = 1'b1;
               idx_d    = 7'd0;
               serial_d = 1'b0;
               active_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SOF: begin
            if (bit_tick) begin
               state_d  = ST_BITS;
               idx_d    = 7'd1;
               serial_d = shift_q[1];
               shift_d  = {shift_q[0], shift_q[78:1]};
            end else begin
               serial_d = 1'b0;
            end
         end
         ST_BITS: begin
            if (bit_tick) begin
               if (idx_q == LAST_IDX) begin
                  state_d  = ST_STOP;
                  serial_d = 1'b1;
               end else begin
                  idx_d    = idx_q + 7'd1;
                  serial_d = shift_q[1];
                  shift_d  = {shift_q[0], shift_q[78:1]};
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_STOP: begin
            serial_d = 1'b1;
            if (bit_tick) begin
`ifdef CAN_TX_IFS_EN
               state_d   = ST_IFS;
               ifs_cnt_d = 2'd0;
`else
               state_d  = ST_CLEANUP;
               active_d = 1'b0;
               done_d   = 1'b1;
`endif
            end else begin
               state_d = ST_STOP;
            end
         end
`ifdef CAN_TX_IFS_EN
         ST_IFS: begin
            serial_d = 1'b1;
            if (bit_tick) begin
               if (ifs_cnt_q == LAST_IFS) begin
                  state_d  = ST_CLEANUP;
                  active_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  ifs_cnt_d = ifs_cnt_q + 2'd1;
               end
            end else begin
               state_d = ST_IFS;
            end
         end
`endif
         ST_CLEANUP: begin
            restart  = 1'b1;
            serial_d = 1'b1;
            if (hold_full_q) begin
               state_d  = ST_SOF;
               shift_d  = hold_q;
               start    = 1'b1;
               idx_d    = 7'd0;
               serial_d = 1'b0;
               active_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
            restart  = 1'b1;
         end
      endcase

      hold_full_d = start ? 1'b0 : (hold_full_q | accept);
   end

   // state and datapath registers
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q     <= ST_IDLE;
         shift_q     <= 79'd0;
         hold_q      <= 79'd0;
         hold_full_q <= 1'b0;
         idx_q       <= 7'd0;
         serial_q    <= 1'b1;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
`ifdef CAN_TX_IFS_EN
         ifs_cnt_q   <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         idx_q       <= idx_d;
         serial_q    <= serial_d;
         active_q    <= active_d;
         done_q      <= done_d;
`ifdef CAN_TX_IFS_EN
         ifs_cnt_q   <= ifs_cnt_d;
`endif
      end
   end

   assign o_Tx_Ready  = ~hold_full_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;

endmodule
